sv32_page_table_walker: RTL and testbench

SV32_PAGE_TABLE_WALKER -- requirements
Module: sv32_page_table_walker

---
 rtl/sv32_page_table_walker.sv | 157 +++++++++++++++
 tb/tb_sv32_page_table_walker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sv32_page_table_walker.sv
// Sv32 hardware page-table walker.
// Walks the two-level Sv32 table for one virtual address per request and
// returns either a flattened leaf PTE or 32'h0 to signal a fault.
//
// Ports
//   clk        clock, rising edge
//   resetn     asynchronous active-low reset
//   address    virtual address, captured when a walk starts
//   satp       satp CSR; bits [21:0] (root PPN) captured when a walk starts
//   valid      walk request
//   ready      one-cycle walk-complete pulse
//   pte        result {phys_addr[31:12], 4'b0000, flags[7:0]}; 0 = fault
//   mem_valid  PTE read request
//   mem_addr   34-bit physical byte address of the PTE read
//   mem_ready  read complete; mem_rdata valid in the same cycle
//   mem_rdata  raw PTE read data
module sv32_page_table_walker (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] satp,
    input  logic        valid,
    output logic        ready,
    output logic [31:0] pte,
    output logic        mem_valid,
    output logic [33:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, LVL1, LVL0, DONE} state_t;

    state_t      state, state_next;

    // Only the fields the walk actually uses are kept.
    logic [19:0] vpn_q;       // {VPN1, VPN0}
    logic [21:0] root_ppn_q;
    logic [21:0] l1_ppn_q;    // PPN of the level-1 pointer PTE

    logic        start;
    logic        l1_load;
    logic        pte_load;
    logic [31:0] pte_next;

    logic [9:0]  vpn1;
    logic [9:0]  vpn0;
    logic [33:0] l1_addr;
    logic [33:0] l0_addr;

    logic        pte_v, pte_r, pte_w, pte_x, pte_a;
    logic        is_leaf;
    logic        is_bad;

    logic        unused_bits;
    assign unused_bits = ^{satp[31:22], address[11:0], mem_rdata[9:8]};

    assign vpn1    = vpn_q[19:10];
    assign vpn0    = vpn_q[9:0];
    assign l1_addr = {root_ppn_q, 12'b0} + {22'b0, vpn1, 2'b00};
    assign l0_addr = {l1_ppn_q, 12'b0} + {22'b0, vpn0, 2'b00};

    assign pte_v   = mem_rdata[0];
    assign pte_r   = mem_rdata[1];
    assign pte_w   = mem_rdata[2];
    assign pte_x   = mem_rdata[3];
    assign pte_a   = mem_rdata[6];
    assign is_leaf = pte_r | pte_x;
    // Faults common to both levels: invalid, reserved W-without-R, leaf with A clear.
    assign is_bad  = !pte_v || (pte_w && !pte_r) || (is_leaf && !pte_a);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        start      = 1'b0;
        l1_load    = 1'b0;
        pte_load   = 1'b0;
        pte_next   = '0;

        case (state)
            IDLE: begin
                if (valid) begin
                    start      = 1'b1;
                    state_next = LVL1;
                end
            end
            LVL1: begin
                mem_valid = 1'b1;
                mem_addr  = l1_addr;
                if (mem_ready) begin
                    if (is_bad) begin
                        pte_load   = 1'b1;
                        state_next = DONE;
                    end else if (is_leaf) begin
                        pte_load   = 1'b1;
                        // Superpage: low PPN bits must be zero and PPN must fit 32 bits.
                        if (mem_rdata[19:10] == '0 && mem_rdata[31:30] == '0) begin
                            pte_next = {mem_rdata[29:20], vpn0, 4'b0000, mem_rdata[7:0]};
                        end
                        state_next = DONE;
                    end else begin
                        l1_load    = 1'b1;
                        state_next = LVL0;
                    end
                end
            end
            LVL0: begin
                mem_valid = 1'b1;
                mem_addr  = l0_addr;
                if (mem_ready) begin
                    pte_load = 1'b1;
                    // A pointer at the last level is a fault (pte_next stays 0).
                    if (!is_bad && is_leaf && mem_rdata[31:30] == '0) begin
                        pte_next = {mem_rdata[29:10], 4'b0000, mem_rdata[7:0]};
                    end
                    state_next = DONE;
                end
            end
            DONE: begin
                // valid is deliberately ignored here so a held request cannot restart.
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vpn_q      <= '0;
            root_ppn_q <= '0;
            l1_ppn_q   <= '0;
            pte        <= '0;
        end else begin
            if (start) begin
                vpn_q      <= address[31:12];
                root_ppn_q <= satp[21:0];
            end
            if (l1_load) begin
                l1_ppn_q <= mem_rdata[31:10];
            end
            if (pte_load) begin
                pte <= pte_next;
            end
        end
    end

endmodule

// File: tb/tb_sv32_page_table_walker.sv
module tb_sv32_page_table_walker;

    logic        clk;
    logic        resetn;
    logic [31:0] address;
    logic [31:0] satp;
    logic        valid;
    logic        ready;
    logic [31:0] pte;
    logic        mem_valid;
    logic [33:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] sb_q[$];

    sv32_page_table_walker dut (
        .clk       (clk),
        .resetn    (resetn),
        .address   (address),
        .satp      (satp),
        .valid     (valid),
        .ready     (ready),
        .pte       (pte),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one walk; inputs change and outputs are sampled on the falling edge.
    // a1/d1 and a0/d0 describe the level-1 and level-0 reads the walk must issue.
    task automatic run_walk(input logic [31:0] va, input logic [31:0] sp,
                            input logic [33:0] a1, input logic [31:0] d1,
                            input logic [33:0] a0, input logic [31:0] d0,
                            input int nreads, input int stall,
                            input logic [31:0] exp_pte, input bit hold);
        int lvl;
        int waited;
        int ready_cyc;
        int exp_cyc;
        logic [31:0] exp;
        exp_cyc = 1 + nreads * (stall + 1);
        sb_q.push_back(exp_pte);
        @(negedge clk);
        valid     = 1'b1;
        address   = va;
        satp      = sp;
        mem_ready = 1'b0;
        lvl       = 0;
        waited    = 0;
        ready_cyc = -1;
        for (int c = 1; c < 100 && ready_cyc < 0; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!hold) valid = 1'b0;
            if (ready) begin
                ready_cyc = c;
            end else if (mem_valid) begin
                if (lvl == 0) check("l1_addr", mem_addr, a1);
                else          check("l0_addr", mem_addr, a0);
                if (waited == stall) begin
                    mem_ready = 1'b1;
                    mem_rdata = (lvl == 0) ? d1 : d0;
                    lvl++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
        end
        check("ready_cycle", ready_cyc, exp_cyc);
        check("read_count", lvl, nreads);
        @(negedge clk);
        valid = 1'b0;
        exp = sb_q.pop_front();
        check("pte", pte, exp);
        check("ready_pulse", ready, 1'b0);
        check("no_restart", mem_valid, 1'b0);
        @(negedge clk);
        check("pte_hold", pte, exp);
        check("idle_ready", ready, 1'b0);
        check("idle_mem", mem_valid, 1'b0);
    endtask

    task automatic reset_mid_walk();
        @(negedge clk);
        valid   = 1'b1;
        address = 32'h0040_1234;
        satp    = 32'h8000_0080;
        @(negedge clk);
        valid = 1'b0;
        check("rst_l1_addr", mem_addr, 34'h8_0004);
        mem_ready = 1'b1;
        mem_rdata = 32'h0002_0C01;
        @(negedge clk);
        check("rst_lvl0_valid", mem_valid, 1'b1);
        check("rst_l0_addr", mem_addr, 34'h8_3004);
        // Leave a response pending across reset.
        mem_rdata = 32'h1234_50CB;
        #2 resetn = 1'b0;
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_mem_addr", mem_addr, 34'h0);
        check("rst_pte", pte, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        check("post_rst_mem_valid", mem_valid, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        check("post_rst_idle", mem_valid, 1'b0);
        check("post_rst_ready", ready, 1'b0);
        check("post_rst_pte", pte, 32'h0);
    endtask

    initial begin
        resetn    = 1'b0;
        address   = '0;
        satp      = '0;
        valid     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        check("reset_ready", ready, 1'b0);
        check("reset_mem_valid", mem_valid, 1'b0);
        check("reset_mem_addr", mem_addr, 34'h0);
        check("reset_pte", pte, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // 4 KiB page
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0002_0C01,
                 34'h8_3004, 32'h1234_50CB, 2, 0, 32'h48D1_40CB, 1'b0);
        // Superpage
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h2000_00CF,
                 34'h0, 32'h0, 1, 0, 32'h8000_10CF, 1'b0);
        // Misaligned superpage
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h2000_04CF,
                 34'h0, 32'h0, 1, 0, 32'h0, 1'b0);
        // Top-of-range superpage: 34-bit table address
        run_walk(32'hFFC0_0000, 32'h003F_FFFF, 34'h3_FFFF_FFFC, 32'h3FF0_00CF,
                 34'h0, 32'h0, 1, 0, 32'hFFC0_00CF, 1'b0);
        // Invalid L1 entry
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0,
                 34'h0, 32'h0, 1, 0, 32'h0, 1'b0);
        // 4 KiB page again so the next fault walk clears a nonzero pte
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0002_0C01,
                 34'h8_3004, 32'h1234_50CB, 2, 0, 32'h48D1_40CB, 1'b0);
        // W=1 R=0 at L1
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0000_0005,
                 34'h0, 32'h0, 1, 0, 32'h0, 1'b0);
        // Superpage with PPN above 32 bits
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'hE000_00CF,
                 34'h0, 32'h0, 1, 0, 32'h0, 1'b0);
        // Leaf with A=0 at L0
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0002_0C01,
                 34'h8_3004, 32'h1234_500B, 2, 0, 32'h0, 1'b0);
        // Pointer at L0
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0002_0C01,
                 34'h8_3004, 32'h0000_0401, 2, 0, 32'h0, 1'b0);
        // L0 leaf with PPN above 32 bits
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0002_0C01,
                 34'h8_3004, 32'h5234_50CB, 2, 0, 32'h0, 1'b0);
        // Back-pressure: 5 stall cycles per level
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0002_0C01,
                 34'h8_3004, 32'h1234_50CB, 2, 5, 32'h48D1_40CB, 1'b0);
        // valid held through the ready cycle
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0002_0C01,
                 34'h8_3004, 32'h1234_50CB, 2, 0, 32'h48D1_40CB, 1'b1);
        // Reset during LVL0, then a fresh complete walk
        reset_mid_walk();
        run_walk(32'h0040_1234, 32'h8000_0080, 34'h8_0004, 32'h0002_0C01,
                 34'h8_3004, 32'h1234_50CB, 2, 0, 32'h48D1_40CB, 1'b0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
